// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture: segment bit positions,
// canonical glyph patterns and the glyph decoder.
package seg7_scan_capture_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] SEG7_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG7_PAT_1 = 7'h06;
  localparam logic [6:0] SEG7_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG7_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG7_PAT_4 = 7'h66;
  localparam logic [6:0] SEG7_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG7_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG7_PAT_7 = 7'h07;
  localparam logic [6:0] SEG7_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG7_PAT_9 = 7'h6F;
  localparam logic [6:0] SEG7_PAT_BLANK = 7'h00;

  localparam logic [3:0] SEG7_BLANK   = 4'hE;
  localparam logic [3:0] SEG7_INVALID = 4'hF;

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
  } glyph_t;

  // Lit-segment pattern (active-high, a..g) to digit value, blank or invalid.
  function automatic logic [3:0] seg7_decode(input logic [6:0] lit);
    logic [3:0] val;
    val = SEG7_INVALID;
    case (lit)
      SEG7_PAT_0:     val = 4'd0;
      SEG7_PAT_1:     val = 4'd1;
      SEG7_PAT_2:     val = 4'd2;
      SEG7_PAT_3:     val = 4'd3;
      SEG7_PAT_4:     val = 4'd4;
      SEG7_PAT_5:     val = 4'd5;
      SEG7_PAT_6:     val = 4'd6;
      SEG7_PAT_7:     val = 4'd7;
      SEG7_PAT_8:     val = 4'd8;
      SEG7_PAT_9:     val = 4'd9;
      SEG7_PAT_BLANK: val = SEG7_BLANK;
      default:        val = SEG7_INVALID;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/seg7_digit_confirm.sv
// Per-digit confirmation: candidate glyph with a saturating confirm count,
// committed register, and the seen/timeout tracker.
module seg7_digit_confirm
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   sample,
  input  glyph_t glyph,
  output glyph_t committed,
  output logic   seen,
  output logic   change_c
);

  localparam int unsigned CONF_W = $clog2(CONFIRM + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  glyph_t             cand;
  logic [CONF_W-1:0]  conf_cnt;
  logic [TO_W-1:0]    idle_cnt;
  logic               confirmed_c;

  assign confirmed_c = (conf_cnt == CONF_MAX);
  assign change_c    = confirmed_c && (cand != committed);

  // Candidate tracking: repeated glyphs build confidence, a new glyph restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cand     <= '0;
      conf_cnt <= '0;
    end else if (sample) begin
      if (glyph == cand) begin
        if (conf_cnt != CONF_MAX) conf_cnt <= conf_cnt + CONF_W'(1);
      end else begin
        cand     <= glyph;
        conf_cnt <= CONF_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      committed.val <= SEG7_INVALID;
      committed.dp  <= 1'b0;
    end else if (confirmed_c) begin
      committed <= cand;
    end
  end

  // A sample restarts the idle count and takes priority over expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seen     <= 1'b0;
      idle_cnt <= '0;
    end else if (sample) begin
      seen     <= 1'b1;
      idle_cnt <= '0;
    end else if (seen) begin
      if (idle_cnt == TO_LAST) seen <= 1'b0;
      else                     idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed 4-digit 7-segment bus: synchronizes the lines,
// samples each settled scan window once and feeds per-digit confirmation.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CONFIRM       = 3,
  parameter int unsigned TIMEOUT       = 1048576
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  seg_n,
  input  logic [3:0]  dig_en,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  seen,
  output logic        update,
  output logic        overlap,
  output logic        decode_err
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_MAX    = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_SAMPLE = SET_W'(SETTLE_CYCLES - 1);

  logic [7:0]        seg_meta, s_seg, prev_seg;
  logic [3:0]        en_meta, s_en, prev_en;
  logic [SET_W-1:0]  settle_cnt;
  logic              armed;

  logic              window_change_c;
  logic              sample_point_c;
  logic              en_onehot_c;
  logic              en_multi_c;
  glyph_t            glyph_c;
  logic [3:0]        dig_sample_c;
  logic [3:0]        commit_change_c;
  glyph_t            committed [NUM_DIGITS];

  // Two-flop synchronizers plus a one-cycle history for change detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_meta <= '0;
      s_seg    <= '0;
      prev_seg <= '0;
      en_meta  <= '0;
      s_en     <= '0;
      prev_en  <= '0;
    end else begin
      seg_meta <= seg_n;
      s_seg    <= seg_meta;
      prev_seg <= s_seg;
      en_meta  <= dig_en;
      s_en     <= en_meta;
      prev_en  <= s_en;
    end
  end

  assign window_change_c = ({s_seg, s_en} != {prev_seg, prev_en});
  assign sample_point_c  = armed && (settle_cnt == SET_SAMPLE);

  // A change re-arms even on the sample cycle; the stable window is still taken from prev_*.
  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (window_change_c) begin
      settle_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      if (settle_cnt != SET_MAX) settle_cnt <= settle_cnt + SET_W'(1);
      if (sample_point_c)        armed      <= 1'b0;
    end
  end

  assign en_onehot_c  = $onehot(prev_en);
  assign en_multi_c   = !en_onehot_c && (prev_en != 4'b0000);
  assign glyph_c.val  = seg7_decode(~prev_seg[SEG_G:SEG_A]);
  assign glyph_c.dp   = ~prev_seg[SEG_DP];
  assign dig_sample_c = (sample_point_c && en_onehot_c) ? prev_en : 4'b0000;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_digit_confirm #(
      .CONFIRM (CONFIRM),
      .TIMEOUT (TIMEOUT)
    ) u_confirm (
      .CLK       (CLK),
      .RST       (RST),
      .sample    (dig_sample_c[i]),
      .glyph     (glyph_c),
      .committed (committed[i]),
      .seen      (seen[i]),
      .change_c  (commit_change_c[i])
    );
    assign digits[4*i +: 4] = committed[i].val;
    assign dp[i]            = committed[i].dp;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      update     <= 1'b0;
      overlap    <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      update     <= |commit_change_c;
      overlap    <= sample_point_c && en_multi_c;
      decode_err <= sample_point_c && en_onehot_c && (glyph_c.val == SEG7_INVALID);
    end
  end

endmodule
